// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves conditional branches, jumps, set-less-than
// and trap/return redirects, queueing results in an in-order FIFO toward
// commit. Also keeps saturating branch / mispredict counters.

package branch_resolve_pkg;
  typedef enum logic [3:0] {
    CMD_BEQ    = 4'd0,
    CMD_BNE    = 4'd1,
    CMD_BLT    = 4'd2,
    CMD_BGE    = 4'd3,
    CMD_BLTU   = 4'd4,
    CMD_BGEU   = 4'd5,
    CMD_JAL    = 4'd6,
    CMD_JALR   = 4'd7,
    CMD_SLT    = 4'd8,
    CMD_SLTU   = 4'd9,
    CMD_ECALL  = 4'd10,
    CMD_EBREAK = 4'd11,
    CMD_MRET   = 4'd12
  } alu_commands_t;

  // Microcode entry points for trap / return redirects.
  localparam logic [31:0] IF_ECALL_UCODE  = 32'h8000_0000;
  localparam logic [31:0] IF_EBREAK_UCODE = 32'h8000_0040;
  localparam logic [31:0] IF_MRET_UCODE   = 32'h8000_0080;
endpackage

module branch_resolve_unit
  import branch_resolve_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TAG_W      = 4,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 32,
  parameter int C_EXT      = 0,
  parameter int INC        = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  alu_commands_t                 cmd,
  input  logic [XLEN-1:0]               arg0,
  input  logic [XLEN-1:0]               arg1,
  input  logic [XLEN-1:0]               addr,
  input  logic [XLEN-1:0]               imm,
  input  logic [REG_ADDR_W-1:0]         i_rd,
  input  logic [TAG_W-1:0]              i_tag,
  input  logic                          predict_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               res,
  output logic [XLEN-1:0]               jmp,
  output logic [REG_ADDR_W-1:0]         o_rd,
  output logic [TAG_W-1:0]              o_tag,
  output logic                          taken,
  output logic                          mispredict,
  output logic                          err_illegal,
  output logic                          err_misalign,
  input  logic                          flush,
  input  logic                          cnt_clr,
  output logic [CNT_W-1:0]              branch_cnt,
  output logic [CNT_W-1:0]              mispredict_cnt,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [XLEN-1:0]       res;
    logic [XLEN-1:0]       jmp;
    logic [REG_ADDR_W-1:0] rd;
    logic [TAG_W-1:0]      tag;
    logic                  taken;
    logic                  mispredict;
    logic                  err_illegal;
    logic                  err_misalign;
  } entry_t;

  entry_t           comp;
  entry_t           head;
  entry_t           mem [DEPTH];
  logic             is_branch;
  logic             is_jump;
  logic             cond;
  logic [XLEN-1:0]  target_rel;
  logic [XLEN-1:0]  target_jalr;
  logic [XLEN-1:0]  fall;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready  = (occ < OCC_W'(DEPTH)) && !flush;
  assign out_valid = (occ != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign occupancy = occ;

  // Resolve the presented operation into a FIFO entry.
  always_comb begin
    comp        = '0;
    comp.tag    = i_tag;
    is_branch   = 1'b0;
    is_jump     = 1'b0;
    cond        = 1'b0;
    target_rel  = addr + imm;
    target_jalr = (arg0 + imm) & ~XLEN'(1);
    fall        = addr + XLEN'(INC);
    case (cmd)
      CMD_BEQ:  begin is_branch = 1'b1; cond = (arg0 == arg1); end
      CMD_BNE:  begin is_branch = 1'b1; cond = (arg0 != arg1); end
      CMD_BLT:  begin is_branch = 1'b1; cond = ($signed(arg0) <  $signed(arg1)); end
      CMD_BGE:  begin is_branch = 1'b1; cond = ($signed(arg0) >= $signed(arg1)); end
      CMD_BLTU: begin is_branch = 1'b1; cond = (arg0 <  arg1); end
      CMD_BGEU: begin is_branch = 1'b1; cond = (arg0 >= arg1); end
      CMD_JAL: begin
        is_jump         = 1'b1;
        comp.taken      = 1'b1;
        comp.jmp        = target_rel;
        comp.res        = fall;
        comp.rd         = i_rd;
        comp.mispredict = !predict_in;
      end
      CMD_JALR: begin
        is_jump         = 1'b1;
        comp.taken      = 1'b1;
        comp.jmp        = target_jalr;
        comp.res        = fall;
        comp.rd         = i_rd;
        comp.mispredict = 1'b1;
      end
      CMD_SLT: begin
        comp.res = XLEN'($signed(arg0) < $signed(arg1));
        comp.rd  = i_rd;
      end
      CMD_SLTU: begin
        comp.res = XLEN'(arg0 < arg1);
        comp.rd  = i_rd;
      end
      CMD_ECALL, CMD_EBREAK, CMD_MRET: begin
        comp.taken      = 1'b1;
        comp.mispredict = 1'b1;
        comp.jmp        = (cmd == CMD_ECALL)  ? XLEN'(IF_ECALL_UCODE) :
                          (cmd == CMD_EBREAK) ? XLEN'(IF_EBREAK_UCODE) :
                                                XLEN'(IF_MRET_UCODE);
      end
      default: comp.err_illegal = 1'b1;
    endcase
    if (is_branch) begin
      comp.taken      = cond;
      comp.jmp        = cond ? target_rel : fall;
      comp.mispredict = cond ^ predict_in;
    end
    // A taken jmp equals the target; a misaligned one must not redirect.
    if ((is_branch || is_jump) && comp.taken &&
        ((C_EXT != 0) ? comp.jmp[0] : (comp.jmp[1:0] != 2'b00))) begin
      comp.err_misalign = 1'b1;
      comp.mispredict   = 1'b0;
    end
  end

  // FIFO storage write at the tail; no reset needed, head is masked when empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= comp;
  end

  // Head outputs read zero whenever the FIFO is empty.
  always_comb begin
    head = out_valid ? mem[rd_ptr] : '0;
  end

  assign res          = head.res;
  assign jmp          = head.jmp;
  assign o_rd         = head.rd;
  assign o_tag        = head.tag;
  assign taken        = head.taken;
  assign mispredict   = head.mispredict;
  assign err_illegal  = head.err_illegal;
  assign err_misalign = head.err_misalign;

  // FIFO pointers and fill level; flush beats push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      if (push && !pop)      occ <= occ + OCC_W'(1);
      else if (pop && !push) occ <= occ - OCC_W'(1);
    end
  end

  // Saturating performance counters, updated at accept time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (cnt_clr) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (push && is_branch && (branch_cnt != '1))
        branch_cnt <= branch_cnt + CNT_W'(1);
      if (push && comp.mispredict && (mispredict_cnt != '1))
        mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a vector table for single
// operations plus hand-written FIFO, flush, counter and reset sequences.

module tb_branch_resolve_unit;
  import branch_resolve_pkg::*;

  localparam int NV = 22;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready;
  alu_commands_t cmd;
  logic [31:0] arg0, arg1, addr, imm, res, jmp;
  logic [4:0]  i_rd, o_rd;
  logic [3:0]  i_tag, o_tag;
  logic predict_in, taken, mispredict, err_illegal, err_misalign;
  logic flush, cnt_clr;
  logic [3:0] branch_cnt, mispredict_cnt;
  logic [2:0] occupancy;

  int total = 0;
  int bad   = 0;
  int exp_b = 0;
  int exp_m = 0;

  typedef struct {
    alu_commands_t c;
    logic [31:0] a0, a1, ad, im;
    logic        pr;
    logic [31:0] e_res, e_jmp;
    logic [4:0]  e_rd;
    logic        e_tk, e_mis, e_ill, e_mal, is_br;
  } vec_t;

  vec_t v [NV];

  branch_resolve_unit #(.DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .cmd(cmd), .arg0(arg0), .arg1(arg1), .addr(addr), .imm(imm),
    .i_rd(i_rd), .i_tag(i_tag), .predict_in(predict_in),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .jmp(jmp),
    .o_rd(o_rd), .o_tag(o_tag), .taken(taken), .mispredict(mispredict),
    .err_illegal(err_illegal), .err_misalign(err_misalign), .flush(flush),
    .cnt_clr(cnt_clr), .branch_cnt(branch_cnt),
    .mispredict_cnt(mispredict_cnt), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Expected saturating counters (4-bit).
  task automatic model_accept(input logic br, input logic mis);
    if (br && exp_b != 15) exp_b++;
    if (mis && exp_m != 15) exp_m++;
  endtask

  task automatic set_op(input alu_commands_t c, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] ad, input logic [31:0] im, input logic pr,
                        input logic [3:0] tg);
    cmd = c; arg0 = a0; arg1 = a1; addr = ad; imm = im; predict_in = pr; i_tag = tg;
  endtask

  task automatic check_cnts(input string tag);
    check({tag, " branch_cnt"}, 32'(branch_cnt), 32'(exp_b));
    check({tag, " mispredict_cnt"}, 32'(mispredict_cnt), 32'(exp_m));
  endtask

  initial begin
    alu_commands_t bad_cmd;
    bad_cmd = alu_commands_t'(4'd15);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    i_rd = 5'd9;
    set_op(CMD_BEQ, 0, 0, 0, 0, 1'b0, 4'd0);

    //            cmd       arg0          arg1          addr          imm           pr   res    jmp              rd    tk   mis  ill  mal  br
    v[0]  = '{CMD_BEQ,  32'd5,        32'd5,        32'h100,      32'h20,       1'b0, 32'd0, 32'h120,         5'd0, 1'b1,1'b1,1'b0,1'b0,1'b1};
    v[1]  = '{CMD_BNE,  32'd7,        32'd7,        32'h200,      32'h10,       1'b1, 32'd0, 32'h204,         5'd0, 1'b0,1'b1,1'b0,1'b0,1'b1};
    v[2]  = '{CMD_BNE,  32'd7,        32'd7,        32'h200,      32'h10,       1'b0, 32'd0, 32'h204,         5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1};
    v[3]  = '{CMD_BLT,  32'hFFFFFFFF, 32'd1,        32'h300,      32'h8,        1'b1, 32'd0, 32'h308,         5'd0, 1'b1,1'b0,1'b0,1'b0,1'b1};
    v[4]  = '{CMD_BLTU, 32'hFFFFFFFF, 32'd1,        32'h300,      32'h8,        1'b0, 32'd0, 32'h304,         5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1};
    v[5]  = '{CMD_BGE,  32'd1,        32'hFFFFFFFF, 32'h400,      32'hFFFFFFF8, 1'b1, 32'd0, 32'h3F8,         5'd0, 1'b1,1'b0,1'b0,1'b0,1'b1};
    v[6]  = '{CMD_BGEU, 32'd1,        32'hFFFFFFFF, 32'h400,      32'hFFFFFFF8, 1'b1, 32'd0, 32'h404,         5'd0, 1'b0,1'b1,1'b0,1'b0,1'b1};
    v[7]  = '{CMD_JALR, 32'h1001,     32'd0,        32'h40,       32'h2,        1'b1, 32'h44,32'h1002,        5'd9, 1'b1,1'b0,1'b0,1'b1,1'b0};
    v[8]  = '{CMD_JALR, 32'h1001,     32'd0,        32'h40,       32'h3,        1'b0, 32'h44,32'h1004,        5'd9, 1'b1,1'b1,1'b0,1'b0,1'b0};
    v[9]  = '{CMD_JAL,  32'd0,        32'd0,        32'h40,       32'h6,        1'b1, 32'h44,32'h46,          5'd9, 1'b1,1'b0,1'b0,1'b1,1'b0};
    v[10] = '{CMD_JAL,  32'd0,        32'd0,        32'h40,       32'h100,      1'b1, 32'h44,32'h140,         5'd9, 1'b1,1'b0,1'b0,1'b0,1'b0};
    v[11] = '{CMD_JAL,  32'd0,        32'd0,        32'h40,       32'h100,      1'b0, 32'h44,32'h140,         5'd9, 1'b1,1'b1,1'b0,1'b0,1'b0};
    v[12] = '{CMD_SLT,  32'hFFFFFFFE, 32'd3,        32'h40,       32'd0,        1'b0, 32'd1, 32'd0,           5'd9, 1'b0,1'b0,1'b0,1'b0,1'b0};
    v[13] = '{CMD_SLTU, 32'hFFFFFFFE, 32'd3,        32'h40,       32'd0,        1'b0, 32'd0, 32'd0,           5'd9, 1'b0,1'b0,1'b0,1'b0,1'b0};
    v[14] = '{CMD_ECALL, 32'd0,       32'd0,        32'h40,       32'd0,        1'b0, 32'd0, IF_ECALL_UCODE,  5'd0, 1'b1,1'b1,1'b0,1'b0,1'b0};
    v[15] = '{CMD_EBREAK,32'd0,       32'd0,        32'h40,       32'd0,        1'b1, 32'd0, IF_EBREAK_UCODE, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b0};
    v[16] = '{CMD_MRET, 32'd0,        32'd0,        32'h40,       32'd0,        1'b1, 32'd0, IF_MRET_UCODE,   5'd0, 1'b1,1'b1,1'b0,1'b0,1'b0};
    v[17] = '{bad_cmd,  32'd5,        32'd5,        32'h100,      32'h20,       1'b1, 32'd0, 32'd0,           5'd0, 1'b0,1'b0,1'b1,1'b0,1'b0};
    v[18] = '{CMD_BEQ,  32'd0,        32'd0,        32'hFFFFFFF0, 32'h20,       1'b1, 32'd0, 32'h10,          5'd0, 1'b1,1'b0,1'b0,1'b0,1'b1};
    v[19] = '{CMD_BNE,  32'd1,        32'd1,        32'hFFFFFFFC, 32'h40,       1'b0, 32'd0, 32'h0,           5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1};
    v[20] = '{CMD_BEQ,  32'd3,        32'd3,        32'h100,      32'h2,        1'b0, 32'd0, 32'h102,         5'd0, 1'b1,1'b0,1'b0,1'b1,1'b1};
    v[21] = '{CMD_BLT,  32'd5,        32'd2,        32'h100,      32'h2,        1'b1, 32'd0, 32'h104,         5'd0, 1'b0,1'b1,1'b0,1'b0,1'b1};

    // Reset state
    #12;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst occupancy", 32'(occupancy), 32'd0);
    check("rst jmp", jmp, 32'd0);
    check("rst res", res, 32'd0);
    check_cnts("rst");
    @(negedge clk); rst = 1'b0;
    #1 check("post-rst in_ready", 32'(in_ready), 32'd1);

    // Table: one op at a time, pushed into an empty FIFO then popped.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      set_op(v[i].c, v[i].a0, v[i].a1, v[i].ad, v[i].im, v[i].pr, 4'(i));
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      model_accept(v[i].is_br, v[i].e_mis);
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d res", i), res, v[i].e_res);
      check($sformatf("v%0d jmp", i), jmp, v[i].e_jmp);
      check($sformatf("v%0d o_rd", i), 32'(o_rd), 32'(v[i].e_rd));
      check($sformatf("v%0d o_tag", i), 32'(o_tag), 32'(i % 16));
      check($sformatf("v%0d taken", i), 32'(taken), 32'(v[i].e_tk));
      check($sformatf("v%0d mispredict", i), 32'(mispredict), 32'(v[i].e_mis));
      check($sformatf("v%0d err_illegal", i), 32'(err_illegal), 32'(v[i].e_ill));
      check($sformatf("v%0d err_misalign", i), 32'(err_misalign), 32'(v[i].e_mal));
      check_cnts($sformatf("v%0d", i));
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check($sformatf("v%0d popped occupancy", i), 32'(occupancy), 32'd0);
    end

    // Fill to DEPTH with commit stalled; head must stay on tag 0.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_op(CMD_BEQ, 1, 1, 32'h1000 + 32'(i) * 32'h10, 0, 1'b1, 4'(i));
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      model_accept(1'b1, 1'b0);
      check($sformatf("fill%0d occupancy", i), 32'(occupancy), 32'(i + 1));
      check($sformatf("fill%0d head tag", i), 32'(o_tag), 32'd0);
      check($sformatf("fill%0d head jmp", i), jmp, 32'h1000);
    end
    check("full in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    set_op(CMD_BEQ, 1, 1, 32'h2000, 0, 1'b0, 4'd9);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("full no-push occupancy", 32'(occupancy), 32'd4);
    check("full stall head tag", 32'(o_tag), 32'd0);
    check_cnts("full no-push");
    @(negedge clk); out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("drain%0d o_tag", i), 32'(o_tag), 32'(i));
      check($sformatf("drain%0d jmp", i), jmp, 32'h1000 + 32'(i) * 32'h10);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check("drained occupancy", 32'(occupancy), 32'd0);
    check("drained out_valid", 32'(out_valid), 32'd0);

    // Flush with a concurrent input: nothing stored, counters untouched.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_op(CMD_BEQ, 2, 2, 32'h3000, 32'h8, 1'b0, 4'(i));
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      model_accept(1'b1, 1'b1);
    end
    check("preflush occupancy", 32'(occupancy), 32'd3);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1;
    #1 check("flush in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush occupancy", 32'(occupancy), 32'd0);
    check("flush out_valid", 32'(out_valid), 32'd0);
    check_cnts("flush");

    // Counter clear, then saturation with 20 mispredicted branches.
    @(negedge clk); cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0; exp_b = 0; exp_m = 0;
    check_cnts("clr");
    @(negedge clk);
    out_ready = 1'b1;
    set_op(CMD_BEQ, 1, 1, 32'h500, 32'h10, 1'b0, 4'd5);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      model_accept(1'b1, 1'b1);
    end
    #1 in_valid = 1'b0;
    check("sat mispredict_cnt", 32'(mispredict_cnt), 32'hF);
    check_cnts("sat");
    @(negedge clk);
    cnt_clr = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0; in_valid = 1'b0; exp_b = 0; exp_m = 0;
    check_cnts("clr-over-inc");
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("sat drained occupancy", 32'(occupancy), 32'd0);

    // Unknown command stays in order between legal ones.
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      case (i)
        1: set_op(CMD_BEQ, 4, 4, 32'h600, 32'h8, 1'b1, 4'd1);
        2: set_op(bad_cmd, 4, 4, 32'h600, 32'h8, 1'b1, 4'd2);
        default: set_op(CMD_JAL, 0, 0, 32'h600, 32'h8, 1'b1, 4'd3);
      endcase
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    model_accept(1'b1, 1'b0);
    check_cnts("illegal seq");
    @(negedge clk); out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("ill%0d o_tag", i), 32'(o_tag), 32'(i));
      check($sformatf("ill%0d err_illegal", i), 32'(err_illegal), (i == 2) ? 32'd1 : 32'd0);
      check($sformatf("ill%0d jmp", i), jmp, (i == 2) ? 32'd0 : 32'h608);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_op(CMD_JALR, 32'h700, 0, 32'h40, 0, 1'b0, 4'(i));
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      model_accept(1'b0, 1'b1);
    end
    check("prerst occupancy", 32'(occupancy), 32'd2);
    check_cnts("prerst");
    @(negedge clk); #2 rst = 1'b1;
    #1;
    exp_b = 0; exp_m = 0;
    check("async rst occupancy", 32'(occupancy), 32'd0);
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst jmp", jmp, 32'd0);
    check_cnts("async rst");
    @(negedge clk); rst = 1'b0;
    #1 check("async rst in_ready", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
